// File: rtl/tr_step_ctrl.sv
// Tracking stepper-motor controller.
// Latches |x - x0| and the direction on each rising edge of data_valid, maps the
// distance to one of three step periods, and drives complete step pulses with a
// fixed high width. Stops in HOLD when on target, with deadzone hysteresis, and
// inserts a direction-setup gap whenever drv_dir changes.
//
// data_valid is a plain strobe with no back-pressure: a sample is taken on the
// first cycle it is seen high, and further high cycles are ignored until it has
// been low for at least one cycle.
module tr_step_ctrl #(
    parameter int W_IN      = 12,
    parameter int W_PER     = 17,
    parameter int DEADZONE  = 9,
    parameter int PER_FAST  = 800,
    parameter int PER_MID   = 39600,
    parameter int PER_SLOW  = 80000,
    parameter int PULSE_W   = 100,
    parameter int DIR_SETUP = 50,
    parameter int W_STEPS   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tr_mode_enable,
    input  logic               data_valid,
    input  logic [W_IN-1:0]    x,
    input  logic [W_IN-1:0]    x0,
    input  logic [W_IN-1:0]    dx1,
    input  logic [W_IN-1:0]    dx2,
    output logic               drv_step,
    output logic               drv_dir,
    output logic               drv_enable,
    output logic [W_PER-1:0]   period,
    output logic [1:0]         state_o,
    output logic [W_STEPS-1:0] step_count
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_TRACK      = 2'd1,
        S_DIR_CHANGE = 2'd2,
        S_HOLD       = 2'd3
    } state_t;

    localparam int W_SET = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

    localparam logic [W_SET-1:0]  SET_LAST = W_SET'(DIR_SETUP - 1);
    localparam logic [W_PER-1:0]  PW       = W_PER'(PULSE_W);
    localparam logic [W_PER-1:0]  PW_LAST  = W_PER'(PULSE_W - 1);
    localparam logic [W_PER-1:0]  P_FAST   = W_PER'(PER_FAST);
    localparam logic [W_PER-1:0]  P_MID    = W_PER'(PER_MID);
    localparam logic [W_PER-1:0]  P_SLOW   = W_PER'(PER_SLOW);
    localparam logic [W_IN-1:0]   DZ       = W_IN'(DEADZONE);
    localparam logic [W_PER-1:0]  ONE_PER  = W_PER'(1);

    // Sample path registers
    logic               dv_q;
    logic [W_IN-1:0]    adx;
    logic               dir_req;
    logic [W_PER-1:0]   period_next;

    // FSM / step engine registers and their next values
    state_t             state, state_n;
    logic [W_PER-1:0]   cnt, cnt_n;
    logic [W_SET-1:0]   set_cnt, set_cnt_n;
    logic [W_PER-1:0]   period_r, period_n;
    logic               dir_r, dir_n;
    logic [W_STEPS-1:0] steps_r, steps_n;

    logic               step_hi;
    logic               boundary;

    // Latch distance and direction on the data_valid rising edge; zone the
    // registered distance into the period for the next step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q        <= 1'b0;
            adx         <= '0;
            dir_req     <= 1'b0;
            period_next <= P_SLOW;
        end else begin
            dv_q <= data_valid;
            if (data_valid && !dv_q) begin
                adx     <= (x >= x0) ? (x - x0) : (x0 - x);
                dir_req <= (x <= x0);
            end
            if (adx >= dx2) begin
                period_next <= P_FAST;
            end else if (adx >= dx1) begin
                period_next <= P_MID;
            end else if (adx != '0) begin
                period_next <= P_SLOW;
            end
        end
    end

    // FSM state, step counter, setup counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            set_cnt  <= '0;
            period_r <= '0;
            dir_r    <= 1'b0;
            steps_r  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            set_cnt  <= set_cnt_n;
            period_r <= period_n;
            dir_r    <= dir_n;
            steps_r  <= steps_n;
        end
    end

    assign step_hi  = (cnt < PW);
    assign boundary = (cnt == (period_r - ONE_PER));

    // Next-state logic: step boundaries, direction changes, hold and abort.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        set_cnt_n = set_cnt;
        period_n  = period_r;
        dir_n     = dir_r;
        steps_n   = steps_r;

        case (state)
            S_IDLE: begin
                period_n = '0;
                cnt_n    = '0;
                if (tr_mode_enable) begin
                    dir_n     = dir_req;
                    set_cnt_n = '0;
                    state_n   = S_DIR_CHANGE;
                end
            end

            S_DIR_CHANGE: begin
                if (!tr_mode_enable) begin
                    state_n  = S_IDLE;
                    period_n = '0;
                end else if (set_cnt == SET_LAST) begin
                    state_n  = S_TRACK;
                    cnt_n    = '0;
                    period_n = period_next;
                end else begin
                    set_cnt_n = set_cnt + 1'b1;
                end
            end

            S_TRACK: begin
                if (!tr_mode_enable) begin
                    // Let a pulse in progress finish its high phase; the
                    // aborted step is never counted.
                    if (step_hi && (cnt != PW_LAST)) begin
                        cnt_n = cnt + ONE_PER;
                    end else begin
                        state_n  = S_IDLE;
                        cnt_n    = '0;
                        period_n = '0;
                    end
                end else if (boundary) begin
                    steps_n  = steps_r + 1'b1;
                    cnt_n    = '0;
                    period_n = period_next;
                    if (adx == '0) begin
                        state_n = S_HOLD;
                    end else if (dir_req != dir_r) begin
                        dir_n     = dir_req;
                        set_cnt_n = '0;
                        state_n   = S_DIR_CHANGE;
                    end
                end else begin
                    cnt_n = cnt + ONE_PER;
                end
            end

            S_HOLD: begin
                if (!tr_mode_enable) begin
                    state_n  = S_IDLE;
                    period_n = '0;
                end else if (adx >= DZ) begin
                    if (dir_req == dir_r) begin
                        state_n  = S_TRACK;
                        cnt_n    = '0;
                        period_n = period_next;
                    end else begin
                        dir_n     = dir_req;
                        set_cnt_n = '0;
                        state_n   = S_DIR_CHANGE;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign drv_step   = (state == S_TRACK) && step_hi;
    assign drv_enable = (state == S_TRACK) || (state == S_DIR_CHANGE);
    assign drv_dir    = dir_r;
    assign period     = period_r;
    assign state_o    = state;
    assign step_count = steps_r;

endmodule
